// File: rtl/lanectrl_dly_pkg.sv
// rtl/lanectrl_dly_pkg.sv - shared types and constants for the lane delay-line sequencer
package lanectrl_dly_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_MOVE,
        ST_GAP,
        ST_TRAIL,
        ST_DONE
    } state_t;

    localparam logic SEL_RX = 1'b0;
    localparam logic SEL_TX = 1'b1;

    // Phase timer width; LEAD/GAP/TRAIL lengths must fit in it.
    localparam int TIMER_W = 8;

    // Saturation limits of a signed (w+1)-bit tap position.
    function automatic int tap_pos_max(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int tap_pos_min(input int w);
        return -(1 << w);
    endfunction

endpackage

// File: rtl/lanectrl_dly_timer.sv
// rtl/lanectrl_dly_timer.sv - reloadable down-counter timing the LEAD, GAP and TRAIL phases
module lanectrl_dly_timer
    import lanectrl_dly_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               tc
);

    logic [TIMER_W-1:0] cnt;

    // Load phase length minus one; count down and park at zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count marks the last cycle of the current phase.
    assign tc = (cnt == '0);

endmodule

// File: rtl/lanectrl_dly_seq.sv
// rtl/lanectrl_dly_seq.sv - delay-line / clock-pause request sequencer (tap tracking: LANECTRL_DLY_TAP_TRACK_EN)
module lanectrl_dly_seq
    import lanectrl_dly_pkg::*;
#(
    parameter int PAUSE_LEAD  = 2,
    parameter int MOVE_GAP    = 3,
    parameter int PAUSE_TRAIL = 2,
    parameter int CNT_W       = 8
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_SEL,
    input  logic             REQ_DIR,
    input  logic             REQ_LOAD,
    input  logic [CNT_W-1:0] REQ_TAPS,
    output logic             DONE,
    output logic             DONE_OOR,
    output logic [CNT_W-1:0] DONE_TAPS,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
    output logic [CNT_W:0]   RX_TAP_POS,
    output logic [CNT_W:0]   TX_TAP_POS
);

    localparam logic [TIMER_W-1:0] LEAD_LD  = TIMER_W'(PAUSE_LEAD - 1);
    localparam logic [TIMER_W-1:0] GAP_LD   = TIMER_W'(MOVE_GAP - 1);
    localparam logic [TIMER_W-1:0] TRAIL_LD = TIMER_W'(PAUSE_TRAIL - 1);

    state_t             state, nxt;
    logic               sel_q, dir_q, ld_q, oor_q;
    logic               sel_n, dir_n, ld_n, oor_n;
    logic [CNT_W-1:0]   taps_q, issued_q, taps_n, issued_n;
    logic               accept, oor_flag, active_n;
    logic               tmr_load, tmr_tc;
    logic [TIMER_W-1:0] tmr_val;

    assign accept   = REQ_VALID && REQ_READY;
    assign oor_flag = (sel_q == SEL_RX) ? RX_DELAY_LINE_OUT_OF_RANGE : TX_DELAY_LINE_OUT_OF_RANGE;

    lanectrl_dly_timer u_timer (
        .clk    (FAB_CLK),
        .resetn (RESET_N),
        .load   (tmr_load),
        .value  (tmr_val),
        .tc     (tmr_tc)
    );

    // Next-state, request capture and phase-timer reload decisions.
    always_comb begin
        nxt      = state;
        sel_n    = sel_q;
        dir_n    = dir_q;
        ld_n     = ld_q;
        taps_n   = taps_q;
        issued_n = issued_q;
        oor_n    = oor_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sel_n    = REQ_SEL;
                    dir_n    = REQ_DIR;
                    ld_n     = REQ_LOAD;
                    taps_n   = REQ_TAPS;
                    issued_n = '0;
                    oor_n    = 1'b0;
                    if (!REQ_LOAD && (REQ_TAPS == '0)) begin
                        nxt = ST_DONE;
                    end else begin
                        nxt      = ST_LEAD;
                        tmr_load = 1'b1;
                        tmr_val  = LEAD_LD;
                    end
                end
            end
            ST_LEAD: begin
                if (tmr_tc) nxt = ST_MOVE;
            end
            ST_MOVE: begin
                nxt      = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
                if (!ld_q) issued_n = issued_q + 1'b1;
            end
            ST_GAP: begin
                if (tmr_tc) begin
                    if (oor_flag || ld_q || (issued_q == taps_q)) begin
                        oor_n    = oor_q | oor_flag;
                        nxt      = ST_TRAIL;
                        tmr_load = 1'b1;
                        tmr_val  = TRAIL_LD;
                    end else begin
                        nxt = ST_MOVE;
                    end
                end
            end
            ST_TRAIL: begin
                if (tmr_tc) nxt = ST_DONE;
            end
            ST_DONE: begin
                nxt = ST_IDLE;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
        active_n = (nxt == ST_LEAD) || (nxt == ST_MOVE) || (nxt == ST_GAP) || (nxt == ST_TRAIL);
    end

    // State, captured request and every output are registered from the next-state view.
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state                <= ST_IDLE;
            sel_q                <= 1'b0;
            dir_q                <= 1'b0;
            ld_q                 <= 1'b0;
            oor_q                <= 1'b0;
            taps_q               <= '0;
            issued_q             <= '0;
            REQ_READY            <= 1'b0;
            DONE                 <= 1'b0;
            DONE_OOR             <= 1'b0;
            DONE_TAPS            <= '0;
            DELAY_LINE_SEL       <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            HS_IO_CLK_PAUSE      <= 1'b0;
        end else begin
            state                <= nxt;
            sel_q                <= sel_n;
            dir_q                <= dir_n;
            ld_q                 <= ld_n;
            oor_q                <= oor_n;
            taps_q               <= taps_n;
            issued_q             <= issued_n;
            REQ_READY            <= (nxt == ST_IDLE);
            DONE                 <= (nxt == ST_DONE);
            HS_IO_CLK_PAUSE      <= active_n;
            DELAY_LINE_SEL       <= active_n && sel_n;
            DELAY_LINE_DIRECTION <= active_n && dir_n;
            DELAY_LINE_MOVE      <= (nxt == ST_MOVE) && !ld_n;
            DELAY_LINE_LOAD      <= (nxt == ST_MOVE) && ld_n;
            if (nxt == ST_DONE) begin
                DONE_OOR  <= oor_n;
                DONE_TAPS <= issued_n;
            end
        end
    end

`ifdef LANECTRL_DLY_TAP_TRACK_EN
    logic signed [CNT_W:0] rx_pos, tx_pos;

    function automatic logic signed [CNT_W:0] step_pos(input logic signed [CNT_W:0] p, input logic up);
        if (up) return (int'(p) >= tap_pos_max(CNT_W)) ? p : p + (CNT_W+1)'(1);
        return (int'(p) <= tap_pos_min(CNT_W)) ? p : p - (CNT_W+1)'(1);
    endfunction

    // Track each side's net tap movement; a reload returns that side to zero.
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            rx_pos <= '0;
            tx_pos <= '0;
        end else if (state == ST_MOVE) begin
            if (sel_q == SEL_TX) tx_pos <= ld_q ? '0 : step_pos(tx_pos, dir_q);
            else                 rx_pos <= ld_q ? '0 : step_pos(rx_pos, dir_q);
        end
    end

    assign RX_TAP_POS = rx_pos;
    assign TX_TAP_POS = tx_pos;
`else
    assign RX_TAP_POS = '0;
    assign TX_TAP_POS = '0;
`endif

endmodule
